mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//   HI/LO multiply/divide responder for the E stage of the 5-stage MIPS pipeline.
//   Accepts a one-cycle Start pulse with operands and op code from E, runs a
//   fixed-latency multicycle operation, holds Busy while running, then commits
//   HI/LO. Also services mthi/mtlo writes; HI/LO outputs feed E's mfhi/mflo select.
// PARAMETERS
//   MULT_CYCLES  5   Busy-high cycles for mult/multu (>=1)
//   DIV_CYCLES   10  Busy-high cycles for div/divu (>=1)
// PORTS
//   Clk     in   1   clock, all state updates on posedge
//   Reset   in   1   synchronous, active-high
//   Start   in   1   one-cycle request; Op/D1/D2 sampled with it
//   Op      in   3   0 mult, 1 multu, 2 div, 3 divu, 4-7 reserved (no-op)
//   D1      in   32  rs operand (multiplicand / dividend)
//   D2      in   32  rt operand (multiplier / divisor)
//   WSrc    in   2   0 none, 1 write HI<=D1 (mthi), 2 write LO<=D1 (mtlo), 3 none
//   HI      out  32  HI register
//   LO      out  32  LO register
//   Busy    out  1   operation in flight
//   Done    out  1   one-cycle pulse in the cycle HI/LO commit becomes visible
// BEHAVIOUR
//   Reset: HI=0, LO=0, Busy=0, Done=0, state IDLE, counter 0; dominates all inputs.
//   FSM: IDLE, RUN.
//   IDLE, Start=1, Op 0-3: latch op result into shadow HI/LO, load counter with
//     MULT_CYCLES or DIV_CYCLES, go RUN. Op 4-7: ignored, stay IDLE.
//   RUN: Busy=1; counter decrements each cycle; on the cycle counter==1, commit
//     shadow to HI/LO, go IDLE. Busy high exactly N cycles: Start sampled at edge T,
//     Busy=1 for edges T+1..T+N, HI/LO and Done=1 visible after edge T+N.
//   HI/LO keep old values throughout RUN (no partial results visible).
//   Done high for one cycle after commit only; low otherwise.
//   Arithmetic: mult = signed 32x32 ->64, multu unsigned; {HI,LO}=product.
//     div: LO=quotient truncated toward zero, HI=remainder with sign of dividend.
//     divu: unsigned quotient/remainder.
//     Div by zero (div/divu): full latency runs, Busy/Done as normal, HI/LO unchanged.
//     div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
//   Priority/boundaries:
//     Start while Busy: ignored (E stalls; unit must not restart or corrupt).
//     WSrc!=0 while Busy: ignored.
//     Start and WSrc!=0 same cycle in IDLE: Start wins, WSrc ignored.
//     WSrc in IDLE: target register updated at that edge, visible next cycle.
//     Start in commit cycle (Busy=1, counter==1): ignored; accepted next cycle.
//     Reset mid-RUN: abort, no commit, HI=LO=0, Busy=0 next cycle.
//   Control contract: E stalls any md instruction while (Start|Busy); unit does
//     not generate stalls itself beyond Busy.
// TESTING
//   mult D1=0xFFFFFFFF D2=2 -> Busy 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE, Done 1 cycle.
//   multu D1=0xFFFFFFFF D2=2 -> HI=0x00000001 LO=0xFFFFFFFE after 5 Busy cycles.
//   div D1=0xFFFFFFF9(-7) D2=2 -> Busy 10 cycles, LO=0xFFFFFFFD HI=0xFFFFFFFF;
//     divu 7/0 with HI=0x11,LO=0x22 -> Busy 10, HI/LO stay 0x11/0x22.
//   During mult Busy: Start div and WSrc=1 D1=0xAAAA -> both ignored, mult result commits.
//   IDLE WSrc=2 D1=0x1234 -> LO=0x1234 next cycle, HI unchanged, Busy stays 0.
//   Start mult, Reset at 3rd Busy cycle -> next cycle Busy=0 HI=LO=0, no Done pulse.

Source files
------------

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the E stage: fixed-latency mult/div with shadow
// result registers, committed to HI/LO in one cycle; also services mthi/mtlo.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic [1:0]  WSrc,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Done
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [31:0]      hi_d, hi_q, lo_d, lo_q;
    logic [31:0]      shi_d, shi_q, slo_d, slo_q;
    logic             swr_d, swr_q;
    logic             busy_d, busy_q, done_d, done_q;

    logic [63:0] mul_a, mul_b, prod;
    logic        sdiv;
    logic [31:0] div_a, div_b, quo_u, rem_u, quo, rem;

    // Signed ops share the unsigned datapath: sign-extend for the multiply,
    // divide magnitudes and restore signs afterwards.
    always_comb begin
        mul_a = Op[0] ? {32'b0, D1} : {{32{D1[31]}}, D1};
        mul_b = Op[0] ? {32'b0, D2} : {{32{D2[31]}}, D2};
        prod  = mul_a * mul_b;
        sdiv  = ~Op[0];
        div_a = (sdiv && D1[31]) ? -D1 : D1;
        div_b = (sdiv && D2[31]) ? -D2 : D2;
        quo_u = (div_b == 32'd0) ? 32'd0 : div_a / div_b;
        rem_u = (div_b == 32'd0) ? 32'd0 : div_a % div_b;
        quo   = (sdiv && (D1[31] ^ D2[31])) ? -quo_u : quo_u;
        rem   = (sdiv && D1[31]) ? -rem_u : rem_u;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        shi_d   = shi_q;
        slo_d   = slo_q;
        swr_d   = swr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start && !Op[2]) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    if (Op[1]) begin
                        cnt_d = CNT_W'(DIV_CYCLES);
                        shi_d = rem;
                        slo_d = quo;
                        swr_d = (D2 != 32'd0);
                    end else begin
                        cnt_d = CNT_W'(MULT_CYCLES);
                        shi_d = prod[63:32];
                        slo_d = prod[31:0];
                        swr_d = 1'b1;
                    end
                end else if (WSrc == 2'd1) begin
                    hi_d = D1;
                end else if (WSrc == 2'd2) begin
                    lo_d = D1;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (swr_q) begin
                        hi_d = shi_q;
                        lo_d = slo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            shi_q   <= '0;
            slo_q   <= '0;
            swr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            shi_q   <= shi_d;
            slo_q   <= slo_d;
            swr_q   <= swr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign Busy = busy_q;
    assign Done = done_q;
endmodule
